// File: rtl/prog_sequencer.sv
// prog_sequencer: streams a small program image (up to DEPTH bytes) into the
// cpu `in` port, one byte per clock. When no program byte is issued it drives
// NOP_CODE with o_out_valid low.
// Optional feature macro: PSEQ_LOOP_EN. When it is defined, i_loop=1 at the
// end of the program wraps back to byte 0 without a bubble. When it is
// undefined, i_loop is ignored and every run ends in DONE.
module prog_sequencer #(
  parameter int          DEPTH    = 16,
  parameter int          AW       = 4,
  parameter logic [7:0]  NOP_CODE = 8'h40
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_load_en,
  input  logic [AW-1:0] i_load_addr,
  input  logic [7:0]    i_load_data,
  input  logic [AW:0]   i_prog_len,
  input  logic          i_start,
  input  logic          i_hold,
  input  logic          i_abort,
  input  logic          i_loop,
  output logic [7:0]    o_out_data,
  output logic          o_out_valid,
  output logic          o_busy,
  output logic          o_done,
  output logic [AW-1:0] o_pc
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [AW:0]   DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LEN_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PC_ONE  = AW'(1);

  logic [7:0]    r_mem [DEPTH];
  state_t        r_state, w_state_nxt;
  logic [AW-1:0] r_pc, w_pc_nxt;
  logic [AW:0]   r_len, w_len_nxt;
  logic [7:0]    r_out_data, w_out_data_nxt;
  logic          r_out_valid, w_out_valid_nxt;
  logic          w_last;
  logic          w_loop;

  // Lengths beyond the image size are clamped to the full image.
  function automatic logic [AW:0] clamp_len(input logic [AW:0] len);
    clamp_len = (len > DEPTH_L) ? DEPTH_L : len;
  endfunction

`ifdef PSEQ_LOOP_EN
  assign w_loop = i_loop;
`else
  logic w_unused_loop;
  assign w_unused_loop = i_loop;
  assign w_loop        = 1'b0;
`endif

  assign w_last = ({1'b0, r_pc} == (r_len - LEN_ONE));

  // Image write port: only accepted while not streaming; never cleared by reset.
  always_ff @(posedge clk) begin
    if (i_load_en && (r_state != S_RUN))
      r_mem[i_load_addr] <= i_load_data;
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_pc        <= '0;
      r_len       <= '0;
      r_out_data  <= NOP_CODE;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_len       <= w_len_nxt;
      r_out_data  <= w_out_data_nxt;
      r_out_valid <= w_out_valid_nxt;
    end
  end

  // Next-state and next-output logic; abort beats hold beats issue in RUN.
  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_len_nxt       = r_len;
    w_out_data_nxt  = NOP_CODE;
    w_out_valid_nxt = 1'b0;
    case (r_state)
      S_RUN: begin
        if (i_abort) begin
          w_state_nxt = S_IDLE;
          w_pc_nxt    = '0;
        end else if (!i_hold) begin
          w_out_data_nxt  = r_mem[r_pc];
          w_out_valid_nxt = 1'b1;
          if (w_last) begin
            w_pc_nxt = '0;
            if (!w_loop)
              w_state_nxt = S_DONE;
          end else begin
            w_pc_nxt = r_pc + PC_ONE;
          end
        end
      end
      default: begin
        if (i_start && (i_prog_len != '0)) begin
          w_len_nxt   = clamp_len(i_prog_len);
          w_pc_nxt    = '0;
          w_state_nxt = S_RUN;
        end
      end
    endcase
  end

  assign o_out_data  = r_out_data;
  assign o_out_valid = r_out_valid;
  assign o_busy      = (r_state == S_RUN);
  assign o_done      = (r_state == S_DONE);
  assign o_pc        = r_pc;

endmodule

// File: tb/tb_prog_sequencer.sv
// Testbench for prog_sequencer (default build, PSEQ_LOOP_EN undefined).
module tb_prog_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       load_en = 1'b0;
  logic [3:0] load_addr = '0;
  logic [7:0] load_data = '0;
  logic [4:0] prog_len = '0;
  logic       start = 1'b0;
  logic       hold = 1'b0;
  logic       abort = 1'b0;
  logic       loop = 1'b0;
  logic [7:0] out_data;
  logic       out_valid;
  logic       busy;
  logic       done;
  logic [3:0] pc;

  int n_pass = 0;
  int n_total = 0;

  prog_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .i_load_en   (load_en),
    .i_load_addr (load_addr),
    .i_load_data (load_data),
    .i_prog_len  (prog_len),
    .i_start     (start),
    .i_hold      (hold),
    .i_abort     (abort),
    .i_loop      (loop),
    .o_out_data  (out_data),
    .o_out_valid (out_valid),
    .o_busy      (busy),
    .o_done      (done),
    .o_pc        (pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       ld;
    logic [3:0] la;
    logic [7:0] ldat;
    logic [4:0] plen;
    logic       st;
    logic       hd;
    logic       ab;
    logic [7:0] e_data;
    logic       e_vld;
    logic       e_busy;
    logic       e_done;
    logic [3:0] e_pc;
  } vec_t;

  localparam int NV = 20;
  vec_t vt[NV];
  logic [7:0] model [16];

  task automatic cyc(input logic r, input logic ld, input logic [3:0] la,
                     input logic [7:0] ldat, input logic [4:0] pl,
                     input logic st, input logic hd, input logic ab);
    reset = r; load_en = ld; load_addr = la; load_data = ldat;
    prog_len = pl; start = st; hold = hd; abort = ab;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic chk_out(input string tag, input logic [7:0] d, input logic v,
                         input logic b, input logic dn, input logic [3:0] p);
    chk({tag, ".data"},  int'(out_data),  int'(d));
    chk({tag, ".valid"}, int'(out_valid), int'(v));
    chk({tag, ".busy"},  int'(busy),      int'(b));
    chk({tag, ".done"},  int'(done),      int'(dn));
    chk({tag, ".pc"},    int'(pc),        int'(p));
  endtask

  initial begin
    model[0] = 8'h61; model[1] = 8'h72; model[2] = 8'h03; model[3] = 8'hB3;
    for (int i = 4; i < 16; i++) model[i] = 8'hA0 + 8'(i);

    //           rst ld la ldat   plen st hd ab   data  v  b  d  pc
    vt[0]  = '{1, 0, 0, 8'h00, 0, 0, 0, 0, 8'h40, 0, 0, 0, 0};
    vt[1]  = '{0, 1, 0, 8'h61, 0, 0, 0, 0, 8'h40, 0, 0, 0, 0};
    vt[2]  = '{0, 1, 1, 8'h72, 0, 0, 0, 0, 8'h40, 0, 0, 0, 0};
    vt[3]  = '{0, 1, 2, 8'h03, 0, 0, 0, 0, 8'h40, 0, 0, 0, 0};
    vt[4]  = '{0, 1, 3, 8'hB3, 0, 0, 0, 0, 8'h40, 0, 0, 0, 0};
    vt[5]  = '{0, 0, 0, 8'h00, 4, 1, 0, 0, 8'h40, 0, 1, 0, 0};
    vt[6]  = '{0, 0, 0, 8'h00, 0, 0, 0, 0, 8'h61, 1, 1, 0, 1};
    vt[7]  = '{0, 0, 0, 8'h00, 0, 0, 0, 0, 8'h72, 1, 1, 0, 2};
    vt[8]  = '{0, 0, 0, 8'h00, 0, 0, 0, 0, 8'h03, 1, 1, 0, 3};
    vt[9]  = '{0, 0, 0, 8'h00, 0, 0, 0, 0, 8'hB3, 1, 0, 1, 0};
    vt[10] = '{0, 0, 0, 8'h00, 0, 0, 0, 0, 8'h40, 0, 0, 1, 0};
    vt[11] = '{0, 0, 0, 8'h00, 4, 1, 0, 0, 8'h40, 0, 1, 0, 0};
    vt[12] = '{0, 0, 0, 8'h00, 0, 0, 0, 0, 8'h61, 1, 1, 0, 1};
    vt[13] = '{0, 0, 0, 8'h00, 0, 0, 1, 0, 8'h40, 0, 1, 0, 1};
    vt[14] = '{0, 0, 0, 8'h00, 0, 0, 1, 0, 8'h40, 0, 1, 0, 1};
    vt[15] = '{0, 0, 0, 8'h00, 0, 0, 0, 0, 8'h72, 1, 1, 0, 2};
    vt[16] = '{0, 0, 0, 8'h00, 0, 0, 0, 0, 8'h03, 1, 1, 0, 3};
    vt[17] = '{0, 0, 0, 8'h00, 0, 0, 0, 0, 8'hB3, 1, 0, 1, 0};
    vt[18] = '{1, 0, 0, 8'h00, 0, 0, 0, 0, 8'h40, 0, 0, 0, 0};
    vt[19] = '{0, 0, 0, 8'h00, 0, 1, 0, 0, 8'h40, 0, 0, 0, 0};

    @(negedge clk);
    for (int i = 0; i < NV; i++) begin
      cyc(vt[i].rst, vt[i].ld, vt[i].la, vt[i].ldat, vt[i].plen,
          vt[i].st, vt[i].hd, vt[i].ab);
      chk_out($sformatf("vec%0d", i), vt[i].e_data, vt[i].e_vld,
              vt[i].e_busy, vt[i].e_done, vt[i].e_pc);
    end

    // Full image with an oversized length: clamped to 16, pc wraps to 0.
    for (int i = 4; i < 16; i++) begin
      cyc(0, 1, 4'(i), model[i], 0, 0, 0, 0);
    end
    cyc(0, 0, 0, 0, 20, 1, 0, 0);
    chk_out("clamp.start", 8'h40, 0, 1, 0, 0);
    for (int i = 0; i < 16; i++) begin
      cyc(0, 0, 0, 0, 0, 0, 0, 0);
      if (i < 15) chk_out($sformatf("clamp.b%0d", i), model[i], 1, 1, 0, 4'(i + 1));
      else        chk_out("clamp.last", model[i], 1, 0, 1, 0);
    end
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    chk_out("clamp.after", 8'h40, 0, 0, 1, 0);

    // Abort together with hold mid-run; a write attempted during RUN is dropped.
    cyc(0, 0, 0, 0, 4, 1, 0, 0);
    chk_out("ab.run", 8'h40, 0, 1, 0, 0);
    cyc(0, 1, 0, 8'hFF, 0, 0, 0, 0);
    chk_out("ab.b0", 8'h61, 1, 1, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    chk_out("ab.b1", 8'h72, 1, 1, 0, 2);
    cyc(0, 0, 0, 0, 0, 0, 1, 1);
    chk_out("ab.idle", 8'h40, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 4, 1, 0, 0);
    chk_out("ab.rerun", 8'h40, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    chk_out("ab.mem0", 8'h61, 1, 1, 0, 1);

    // Synchronous reset mid-run, then replay of the retained image.
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    chk_out("rs.b1", 8'h72, 1, 1, 0, 2);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    chk_out("rs.reset", 8'h40, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 4, 1, 0, 0);
    chk_out("rs.run", 8'h40, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 0, 0, 0, 0, 0);
      if (i < 3) chk_out($sformatf("rs.b%0d", i), model[i], 1, 1, 0, 4'(i + 1));
      else       chk_out("rs.last", model[i], 1, 0, 1, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
